// File: rtl/dma_mch_ctrl.sv
// Multi-channel DMA controller: CPU register map, per-channel IDLE/ACTIVE/DRAIN
// sequencers and a fixed/round-robin beat arbiter on a valid/ack transfer port.
module dma_mch_ctrl #(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h400,
  parameter logic [31:0] ADDR_INC  = 32'd4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_en,
  input  logic                                    rd_en,
  input  logic [31:0]                             addr,
  input  logic [31:0]                             wdata,
  output logic [31:0]                             rdata,
  output logic                                    rvalid,
  output logic                                    irq,
  output logic [NUM_CH-1:0]                       ch_busy,
  output logic                                    xfer_req,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] xfer_ch,
  output logic [31:0]                             xfer_src,
  output logic [31:0]                             xfer_dst,
  input  logic                                    xfer_ack
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} ch_state_t;

  logic              r_en, r_arb_rr, r_req, r_rvalid;
  logic [NUM_CH-1:0] r_girq, r_mask, r_auto, r_done, r_abt;
  logic [CH_W-1:0]   r_ch, r_rr_ptr;
  logic [31:0]       r_xsrc, r_xdst, r_rdata;
  ch_state_t         r_state   [NUM_CH];
  logic [CNT_W-1:0]  r_len     [NUM_CH];
  logic [CNT_W-1:0]  r_cnt     [NUM_CH];
  logic [31:0]       r_src     [NUM_CH];
  logic [31:0]       r_dst     [NUM_CH];
  logic [31:0]       r_cur_src [NUM_CH];
  logic [31:0]       r_cur_dst [NUM_CH];

  logic [31:0]       w_off, w_rdata, w_gsrc, w_gdst;
  logic [26:0]       w_blk;
  logic [4:0]        w_reg;
  logic              w_glb;
  logic [CH_W-1:0]   w_grant;
  logic [NUM_CH-1:0] w_sel, w_start, w_abort, w_out, w_ack, w_set, w_clr, w_elig, w_ndone, w_nabt;
  ch_state_t         w_nst  [NUM_CH];
  logic [CNT_W-1:0]  w_ncnt [NUM_CH];
  logic [31:0]       w_nsrc [NUM_CH];
  logic [31:0]       w_ndst [NUM_CH];

  // Fixed mode: lowest index; round-robin: first eligible after the last grant.
  function automatic logic [CH_W-1:0] f_pick(input logic [NUM_CH-1:0] el, input logic rr,
                                             input logic [CH_W-1:0] ptr);
    logic [CH_W-1:0]   g;
    logic [NUM_CH-1:0] sh;
    logic              found;
    int                idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = rr ? (int'(ptr) + 1 + k) % NUM_CH : k;
      sh  = el >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        g     = CH_W'(idx);
      end
    end
    return g;
  endfunction

  assign w_off = addr - BASE_ADDR;
  assign w_blk = w_off[31:5];
  assign w_reg = w_off[4:0];
  assign w_glb = (w_blk == '0);
  assign w_clr = (wr_en && w_glb && w_reg == 5'h04) ? wdata[NUM_CH-1:0] : '0;

  always_comb begin
    w_sel = '0; w_start = '0; w_abort = '0; w_out = '0; w_ack = '0;
    w_set = '0; w_elig = '0; w_ndone = r_done; w_nabt = r_abt;
    for (int n = 0; n < NUM_CH; n++) begin
      w_sel[n]   = (w_blk == 27'(n + 1));
      w_start[n] = wr_en && w_sel[n] && (w_reg == 5'h00) && wdata[0];
      w_abort[n] = wr_en && w_sel[n] && (w_reg == 5'h00) && wdata[1];
      w_out[n]   = r_req && (r_ch == CH_W'(n));
      w_ack[n]   = w_out[n] && xfer_ack;
      w_nst[n]   = r_state[n];
      w_ncnt[n]  = r_cnt[n];
      w_nsrc[n]  = r_cur_src[n];
      w_ndst[n]  = r_cur_dst[n];
      if (r_state[n] != S_IDLE && w_ack[n]) begin
        w_ncnt[n] = r_cnt[n] + CNT_W'(1);
        w_nsrc[n] = r_cur_src[n] + ADDR_INC;
        w_ndst[n] = r_cur_dst[n] + ADDR_INC;
      end
      case (r_state[n])
        S_IDLE: begin
          if (w_start[n] && r_len[n] != '0) begin
            w_nst[n] = S_ACTIVE; w_ncnt[n] = '0;
            w_nsrc[n] = r_src[n]; w_ndst[n] = r_dst[n];
            w_ndone[n] = 1'b0; w_nabt[n] = 1'b0;
          end else if (w_start[n]) begin
            w_ndone[n] = 1'b1; w_set[n] = 1'b1;
          end
        end
        S_ACTIVE: begin
          // An abort that lands on the ack edge counts the beat and stops without draining.
          if (w_abort[n]) begin
            if (w_out[n] && !xfer_ack) w_nst[n] = S_DRAIN;
            else begin w_nst[n] = S_IDLE; w_nabt[n] = 1'b1; end
          end else if (w_ack[n] && (r_cnt[n] + CNT_W'(1) == r_len[n])) begin
            w_ndone[n] = 1'b1; w_set[n] = 1'b1;
            if (r_auto[n]) begin
              w_ncnt[n] = '0; w_nsrc[n] = r_src[n]; w_ndst[n] = r_dst[n];
            end else w_nst[n] = S_IDLE;
          end
        end
        S_DRAIN: if (w_ack[n]) begin w_nst[n] = S_IDLE; w_nabt[n] = 1'b1; end
        default: w_nst[n] = S_IDLE;
      endcase
      w_elig[n] = (r_state[n] == S_ACTIVE) && (w_nst[n] == S_ACTIVE) && (w_ncnt[n] != r_len[n]);
    end
  end

  always_comb begin
    w_grant = f_pick(w_elig, r_arb_rr, r_rr_ptr);
    w_gsrc  = '0;
    w_gdst  = '0;
    for (int n = 0; n < NUM_CH; n++)
      if (w_grant == CH_W'(n)) begin w_gsrc = w_nsrc[n]; w_gdst = w_ndst[n]; end
  end

  always_comb begin
    w_rdata = '0;
    if (w_glb)
      case (w_reg)
        5'h00:   w_rdata = {30'b0, r_arb_rr, r_en};
        5'h04:   w_rdata = 32'(r_girq);
        5'h08:   w_rdata = 32'(r_mask);
        default: w_rdata = '0;
      endcase
    for (int n = 0; n < NUM_CH; n++)
      if (w_sel[n])
        case (w_reg)
          5'h00:   w_rdata = {29'b0, r_auto[n], 2'b00};
          5'h04:   w_rdata = 32'(r_len[n]);
          5'h08:   w_rdata = r_src[n];
          5'h0C:   w_rdata = r_dst[n];
          5'h10:   w_rdata = {29'b0, r_abt[n], r_done[n], r_state[n] != S_IDLE};
          5'h14:   w_rdata = 32'(r_cnt[n]);
          default: w_rdata = '0;
        endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en <= 1'b0; r_arb_rr <= 1'b0; r_req <= 1'b0; r_rvalid <= 1'b0;
      r_girq <= '0; r_mask <= '0; r_auto <= '0; r_done <= '0; r_abt <= '0;
      r_ch <= '0; r_rr_ptr <= CH_W'(NUM_CH - 1);
      r_xsrc <= '0; r_xdst <= '0; r_rdata <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        r_state[n] <= S_IDLE; r_len[n] <= '0; r_cnt[n] <= '0;
        r_src[n] <= '0; r_dst[n] <= '0; r_cur_src[n] <= '0; r_cur_dst[n] <= '0;
      end
    end else begin
      if (wr_en && w_glb && w_reg == 5'h00) begin r_en <= wdata[0]; r_arb_rr <= wdata[1]; end
      if (wr_en && w_glb && w_reg == 5'h08) r_mask <= wdata[NUM_CH-1:0];
      r_girq <= (r_girq & ~w_clr) | w_set;
      r_done <= w_ndone;
      r_abt  <= w_nabt;
      for (int n = 0; n < NUM_CH; n++) begin
        r_state[n] <= w_nst[n]; r_cnt[n] <= w_ncnt[n];
        r_cur_src[n] <= w_nsrc[n]; r_cur_dst[n] <= w_ndst[n];
        if (wr_en && w_sel[n]) begin
          if (w_reg == 5'h00) r_auto[n] <= wdata[2];
          if (r_state[n] == S_IDLE)
            case (w_reg)
              5'h04:   r_len[n] <= wdata[CNT_W-1:0];
              5'h08:   r_src[n] <= wdata;
              5'h0C:   r_dst[n] <= wdata;
              default: ;
            endcase
        end
      end
      // Beat port only moves when idle or on an ack, so it stays stable while waiting.
      if (!r_req || xfer_ack) begin
        if (r_en && (|w_elig)) begin
          r_req <= 1'b1; r_ch <= w_grant; r_rr_ptr <= w_grant;
          r_xsrc <= w_gsrc; r_xdst <= w_gdst;
        end else r_req <= 1'b0;
      end
      r_rvalid <= rd_en;
      if (rd_en) r_rdata <= w_rdata;
    end
  end

  always_comb begin
    ch_busy = '0;
    for (int n = 0; n < NUM_CH; n++) ch_busy[n] = (r_state[n] != S_IDLE);
  end

  assign irq      = |(r_girq & r_mask);
  assign rdata    = r_rdata;
  assign rvalid   = r_rvalid;
  assign xfer_req = r_req;
  assign xfer_ch  = r_ch;
  assign xfer_src = r_xsrc;
  assign xfer_dst = r_xdst;
endmodule
